parking_gate_sensor: RTL and testbench

Direction decoder for a parking-lot gate fitted with two IR beam sensors: A on the outside and B on the inside. The block synchronizes and debounces both beams and tracks the order in which a vehicle breaks and clears them. It emits one-cycle `inc` pulses for a completed entry and `dec` pulses for a completed exit. It is the producer side of the `inc`/`dec` interface consumed by the lot occupancy counter.

---
 rtl/parking_gate_sensor_pkg.sv | 28 ++
 rtl/parking_gate_sensor_if.sv | 13 +
 rtl/parking_gate_sensor_debounce.sv | 47 ++++
 rtl/parking_gate_sensor.sv | 172 +++++++++++++++++
 tb/tb_parking_gate_sensor.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/parking_gate_sensor_pkg.sv
// Shared types and beam-pair encodings for the parking gate direction decoder.
// Pairs are packed as {a, b}: a is the outside beam, b is the inside beam.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IN_A   = 3'd1,
    IN_AB  = 3'd2,
    IN_B   = 3'd3,
    OUT_B  = 3'd4,
    OUT_BA = 3'd5,
    OUT_A  = 3'd6,
    ABORT  = 3'd7
  } gate_state_t;

  typedef logic [1:0] beams_t;

  localparam beams_t BEAMS_CLR = 2'b00;
  localparam beams_t BEAMS_A   = 2'b10;
  localparam beams_t BEAMS_B   = 2'b01;
  localparam beams_t BEAMS_AB  = 2'b11;

  // States in which a vehicle is mid-pass; only these are subject to the residency timeout.
  function automatic logic is_pass_state(input gate_state_t s);
    return (s != IDLE) && (s != ABORT);
  endfunction

endpackage

// File: rtl/parking_gate_sensor_if.sv
// Beam inputs and inc/dec/busy/fault outputs of the parking gate sensor.
// master = the sensor block (producer), slave = its environment / occupancy counter.
interface parking_gate_sensor_if;
  logic a_blk;
  logic b_blk;
  logic inc;
  logic dec;
  logic busy;
  logic fault;

  modport master (input a_blk, b_blk, output inc, dec, busy, fault);
  modport slave  (output a_blk, b_blk, input inc, dec, busy, fault);
endinterface

// File: rtl/parking_gate_sensor_debounce.sv
// Two-flop synchronizer plus stability counter for one IR beam; the debounced
// value follows the synchronized value only after DEBOUNCE_CYCLES stable cycles.
module parking_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic deb_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/parking_gate_sensor.sv
// Parking gate direction decoder: debounces beams A/B and emits inc/dec per pass.
// Optional build macro GATE_TIMEOUT_EN aborts a pass that lingers too long in one state.
module parking_gate_sensor
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  parking_gate_sensor_if.master         gate
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic a_deb, b_deb;
  beams_t pair;

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (gate.a_blk),
    .deb_o  (a_deb)
  );

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (gate.b_blk),
    .deb_o  (b_deb)
  );

  assign pair = {a_deb, b_deb};

  gate_state_t state_q, state_d;
  logic        inc_q, inc_d;
  logic        dec_q, dec_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;

`ifdef GATE_TIMEOUT_EN
  localparam int unsigned RES_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(TIMEOUT_CYCLES - 1);
  logic [RES_W-1:0] res_q, res_d;
`endif

  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        case (pair)
          BEAMS_A:  state_d = IN_A;
          BEAMS_B:  state_d = OUT_B;
          BEAMS_AB: state_d = ABORT;
          default:  state_d = IDLE;
        endcase
      end
      IN_A: begin
        case (pair)
          BEAMS_AB:  state_d = IN_AB;
          BEAMS_CLR: state_d = IDLE;
          BEAMS_B:   state_d = ABORT;
          default:   state_d = IN_A;
        endcase
      end
      IN_AB: begin
        case (pair)
          BEAMS_B:   state_d = IN_B;
          BEAMS_A:   state_d = IN_A;
          BEAMS_CLR: state_d = ABORT;
          default:   state_d = IN_AB;
        endcase
      end
      IN_B: begin
        case (pair)
          BEAMS_CLR: begin
            state_d = IDLE;
            inc_d   = 1'b1;
          end
          BEAMS_AB:  state_d = IN_AB;
          BEAMS_A:   state_d = ABORT;
          default:   state_d = IN_B;
        endcase
      end
      OUT_B: begin
        case (pair)
          BEAMS_AB:  state_d = OUT_BA;
          BEAMS_CLR: state_d = IDLE;
          BEAMS_A:   state_d = ABORT;
          default:   state_d = OUT_B;
        endcase
      end
      OUT_BA: begin
        case (pair)
          BEAMS_A:   state_d = OUT_A;
          BEAMS_B:   state_d = OUT_B;
          BEAMS_CLR: state_d = ABORT;
          default:   state_d = OUT_BA;
        endcase
      end
      OUT_A: begin
        case (pair)
          BEAMS_CLR: begin
            state_d = IDLE;
            dec_d   = 1'b1;
          end
          BEAMS_AB:  state_d = OUT_BA;
          BEAMS_B:   state_d = ABORT;
          default:   state_d = OUT_A;
        endcase
      end
      ABORT: begin
        if (pair == BEAMS_CLR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef GATE_TIMEOUT_EN
    // A real beam transition takes precedence; the timeout only fires while the state would hold.
    if (is_pass_state(state_q) && (state_d == state_q) && (res_q == RES_LAST)) begin
      state_d = ABORT;
    end
    if ((state_d != state_q) || !is_pass_state(state_q)) begin
      res_d = '0;
    end else begin
      res_d = res_q + 1'b1;
    end
`endif

    busy_d  = (state_d != IDLE);
    fault_d = (state_d == ABORT) && (state_q != ABORT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

`ifdef GATE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end
`endif

  assign gate.inc   = inc_q;
  assign gate.dec   = dec_q;
  assign gate.busy  = busy_q;
  assign gate.fault = fault_q;

endmodule

// File: tb/tb_parking_gate_sensor.sv
// Scoreboard bench for parking_gate_sensor with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.
// Expected pulses (kind + cycle) are queued when the causing beam change is driven.
module tb_parking_gate_sensor;

  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 50;
  // Change driven at a negedge -> sampled at the next edge (edge 0) -> pulse on edge DEB+2.
  localparam int unsigned LAT = DEB + 3;

  localparam logic [2:0] K_INC = 3'b100;
  localparam logic [2:0] K_DEC = 3'b010;
  localparam logic [2:0] K_FLT = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  int unsigned cyc;
  int          n_chk;
  int          n_fail;
  exp_t        sb_q[$];
  exp_t        mon_e;

  parking_gate_sensor_if ifc ();

  parking_gate_sensor #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .gate   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic a, input logic b, input int n,
                       input logic [2:0] kind, input int unsigned lat);
    ifc.a_blk = a;
    ifc.b_blk = b;
    if (kind != 3'b000) sb_q.push_back('{kind: kind, cyc: cyc + lat});
    repeat (n) @(negedge clk);
  endtask

  task automatic drained(input string tag);
    chk(tag, sb_q.size(), 0);
  endtask

  // Every output pulse must match the head of the scoreboard in kind and cycle.
  always @(negedge clk) begin
    if ({ifc.inc, ifc.dec, ifc.fault} != 3'b000) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, ifc.inc, ifc.dec, ifc.fault}, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pulse_kind", {29'd0, ifc.inc, ifc.dec, ifc.fault}, {29'd0, mon_e.kind});
        chk("pulse_cycle", cyc, mon_e.cyc);
        chk("busy_at_pulse", {31'd0, ifc.busy}, {31'd0, (mon_e.kind == K_FLT)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic seen;
    n_chk      = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    ifc.a_blk  = 1'b0;
    ifc.b_blk  = 1'b0;
    #23;
    chk("reset_outputs", {28'd0, ifc.inc, ifc.dec, ifc.busy, ifc.fault}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, ifc.busy}, 0);

    // Clean entry
    drive(1'b1, 1'b0, 10, 3'b000, LAT);
    chk("entry_busy_in_a", {31'd0, ifc.busy}, 1);
    drive(1'b1, 1'b1, 10, 3'b000, LAT);
    drive(1'b0, 1'b1, 10, 3'b000, LAT);
    drive(1'b0, 1'b0, 10, K_INC, LAT);
    chk("entry_busy_end", {31'd0, ifc.busy}, 0);
    drained("entry_drained");

    // Clean exit
    drive(1'b0, 1'b1, 10, 3'b000, LAT);
    drive(1'b1, 1'b1, 10, 3'b000, LAT);
    drive(1'b1, 1'b0, 10, 3'b000, LAT);
    chk("exit_busy_out_a", {31'd0, ifc.busy}, 1);
    drive(1'b0, 1'b0, 10, K_DEC, LAT);
    chk("exit_busy_end", {31'd0, ifc.busy}, 0);
    drained("exit_drained");

    // Back-out
    drive(1'b1, 1'b0, 10, 3'b000, LAT);
    chk("backout_busy_in_a", {31'd0, ifc.busy}, 1);
    drive(1'b0, 1'b0, 10, 3'b000, LAT);
    chk("backout_busy_end", {31'd0, ifc.busy}, 0);

    // 3-cycle glitch on a_blk must be filtered
    seen = 1'b0;
    ifc.a_blk = 1'b1;
    repeat (3) begin @(negedge clk); seen |= ifc.busy; end
    ifc.a_blk = 1'b0;
    repeat (12) begin @(negedge clk); seen |= ifc.busy; end
    chk("glitch_busy_seen", {31'd0, seen}, 0);

    // Reversal: A, AB, back to A, clear -> no pulse
    drive(1'b1, 1'b0, 10, 3'b000, LAT);
    drive(1'b1, 1'b1, 10, 3'b000, LAT);
    drive(1'b1, 1'b0, 10, 3'b000, LAT);
    chk("reversal_busy_in_a", {31'd0, ifc.busy}, 1);
    drive(1'b0, 1'b0, 10, 3'b000, LAT);
    chk("reversal_busy_end", {31'd0, ifc.busy}, 0);

    // Violation: IN_A sees (0,1) -> ABORT, held until clear
    drive(1'b1, 1'b0, 10, 3'b000, LAT);
    drive(1'b0, 1'b1, 10, K_FLT, LAT);
    chk("violation_busy_held", {31'd0, ifc.busy}, 1);
    drive(1'b0, 1'b0, 10, 3'b000, LAT);
    chk("violation_busy_end", {31'd0, ifc.busy}, 0);
    drained("violation_drained");

    // Reset while in IN_AB, release with both beams still blocked
    drive(1'b1, 1'b0, 10, 3'b000, LAT);
    drive(1'b1, 1'b1, 10, 3'b000, LAT);
    chk("rst_busy_in_ab", {31'd0, ifc.busy}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_outputs_async", {28'd0, ifc.inc, ifc.dec, ifc.busy, ifc.fault}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 10, K_FLT, LAT);
    chk("rst_abort_busy", {31'd0, ifc.busy}, 1);
    drive(1'b0, 1'b0, 10, 3'b000, LAT);
    chk("rst_busy_end", {31'd0, ifc.busy}, 0);
    drained("rst_drained");

`ifdef GATE_TIMEOUT_EN
    // Residency timeout: IN_A entered LAT cycles after the drive, fault TMO cycles later
    drive(1'b1, 1'b0, 80, K_FLT, LAT + TMO);
    chk("timeout_busy_abort", {31'd0, ifc.busy}, 1);
    drive(1'b0, 1'b0, 10, 3'b000, LAT);
    chk("timeout_busy_end", {31'd0, ifc.busy}, 0);
    drained("timeout_drained");
`endif

    repeat (5) @(negedge clk);
    drained("final_drained");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
